// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared pipeline constants for the mult/div path: opcode and
//                ALU-op encodings, instruction field positions, status
//                register and exception codes, and the controller state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Instruction field slice positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int ALUOP_MSB  = 6;
  localparam int ALUOP_LSB  = 2;

  // Encodings
  localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_MULT   = 5'b00110;
  localparam logic [4:0] ALUOP_DIV    = 5'b00111;

  // Exception status defaults
  localparam logic [4:0]  RSTATUS_REG_DEF   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE_DEF = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE_DEF  = 32'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/md_decode.sv
`default_nettype none
// ============================================================================
//  Module      : md_decode
//  Description : Combinational mult/div recognition for a 32-bit instruction.
//                Shared with the stall logic.
//  Ports       : i_insn   - instruction word
//                o_is_md  - R-type with ALU op mult or div
//                o_is_div - R-type div
//  Revision    : 1.0 - initial release
// ============================================================================
module md_decode
  import proc_pkg::*;
(
  input  logic [31:0] i_insn,
  output logic        o_is_md,
  output logic        o_is_div
);

  logic [4:0] w_opcode;
  logic [4:0] w_aluop;
  logic       w_rtype;
  logic       w_unused_bits;

  assign w_opcode = i_insn[OPCODE_MSB:OPCODE_LSB];
  assign w_aluop  = i_insn[ALUOP_MSB:ALUOP_LSB];
  assign w_rtype  = (w_opcode == OPCODE_RTYPE);

  assign o_is_md  = w_rtype && ((w_aluop == ALUOP_MULT) || (w_aluop == ALUOP_DIV));
  assign o_is_div = w_rtype && (w_aluop == ALUOP_DIV);

  // Remaining fields play no part in recognition.
  assign w_unused_bits = ^{i_insn[RD_MSB:ALUOP_MSB+1], i_insn[ALUOP_LSB-1:0]};

endmodule
`default_nettype wire

// File: rtl/multdiv_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_controller
//  Description : Sequences the shared multi-cycle multiply/divide unit.
//                Accepts a mult/div from DX, latches operands, pulses the unit
//                start, waits (with timeout) for the result and then requests
//                the register-file write port.
//  Ports       : clock/reset           - clock, async active-high reset
//                dx_insn/dx_flush      - DX instruction and squash
//                dx_op_a/dx_op_b       - bypassed operands
//                md_ready/md_exception/md_result - unit completion
//                wb_grant              - write-port grant
//                ctrl_mult/ctrl_div    - one-cycle start pulses
//                md_op_a/md_op_b       - held operands
//                busy/inflight_insn    - stall-logic visibility
//                wb_req/wb_rd/wb_data  - write-port request
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_controller
  import proc_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 40,
  parameter logic [4:0]  RSTATUS_REG    = RSTATUS_REG_DEF,
  parameter logic [31:0] MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
  parameter logic [31:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_insn,
  input  logic        dx_flush,
  input  logic [31:0] dx_op_a,
  input  logic [31:0] dx_op_b,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        wb_grant,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  output logic        busy,
  output logic [31:0] inflight_insn,
  output logic        wb_req,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_ctrl_mult;
  logic             r_ctrl_div;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_busy;
  logic [31:0]      r_inflight;
  logic             r_wb_req;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;

  logic             w_is_md;
  logic             w_is_div;
  logic [31:0]      w_exc_code;

  md_decode u_decode (
    .i_insn   (dx_insn),
    .o_is_md  (w_is_md),
    .o_is_div (w_is_div)
  );

  assign w_exc_code = r_is_div ? DIV_EXC_CODE : MULT_EXC_CODE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_busy      <= 1'b0;
      r_inflight  <= '0;
      r_wb_req    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
    end else begin
      // Start strobes live for the START cycle only.
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_is_md && !dx_flush) begin
            r_inflight  <= dx_insn;
            r_op_a      <= dx_op_a;
            r_op_b      <= dx_op_b;
            r_is_div    <= w_is_div;
            r_ctrl_mult <= !w_is_div;
            r_ctrl_div  <= w_is_div;
            r_busy      <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          // A ready seen here belongs to nothing we issued; ignore it.
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          if (md_ready) begin
            r_wb_req <= 1'b1;
            if (md_exception) begin
              r_wb_rd   <= RSTATUS_REG;
              r_wb_data <= w_exc_code;
            end else begin
              r_wb_rd   <= r_inflight[RD_MSB:RD_LSB];
              r_wb_data <= md_result;
            end
            r_state <= WB;
          end else if (r_cnt == CNT_LAST) begin
            r_wb_req  <= 1'b1;
            r_wb_rd   <= RSTATUS_REG;
            r_wb_data <= w_exc_code;
            r_state   <= WB;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WB: begin
          if (wb_grant) begin
            r_wb_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_inflight <= '0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ctrl_mult     = r_ctrl_mult;
  assign ctrl_div      = r_ctrl_div;
  assign md_op_a       = r_op_a;
  assign md_op_b       = r_op_b;
  assign busy          = r_busy;
  assign inflight_insn = r_inflight;
  assign wb_req        = r_wb_req;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_controller
//  Description : Randomized self-checking bench for multdiv_controller. A
//                transaction-level model stands in for the mult/div unit and
//                predicts each operation's pulse, write destination and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_controller;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dx_insn = '0;
  logic        dx_flush = 1'b0;
  logic [31:0] dx_op_a = '0;
  logic [31:0] dx_op_b = '0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;
  logic        wb_grant = 1'b0;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        busy;
  logic [31:0] inflight_insn;
  logic        wb_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  multdiv_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .dx_insn       (dx_insn),
    .dx_flush      (dx_flush),
    .dx_op_a       (dx_op_a),
    .dx_op_b       (dx_op_b),
    .md_ready      (md_ready),
    .md_exception  (md_exception),
    .md_result     (md_result),
    .wb_grant      (wb_grant),
    .ctrl_mult     (ctrl_mult),
    .ctrl_div      (ctrl_div),
    .md_op_a       (md_op_a),
    .md_op_b       (md_op_b),
    .busy          (busy),
    .inflight_insn (inflight_insn),
    .wb_req        (wb_req),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] md_insn(input logic [4:0] rd, input logic is_div);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'b00000;
    r[26:22] = rd;
    r[6:2]   = is_div ? 5'b00111 : 5'b00110;
    return r;
  endfunction

  function automatic logic [31:0] non_md_insn();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[31:27] = 5'($urandom_range(1, 31));
    else begin
      r[31:27] = 5'b0;
      r[6:2]   = 5'($urandom_range(8, 31));
    end
    return r;
  endfunction

  // DX-side traffic while an op is in flight, including held mult/divs.
  task automatic noise();
    dx_insn  = ($urandom_range(0, 1) == 1) ? md_insn(5'($urandom), 1'($urandom)) : non_md_insn();
    dx_op_a  = $urandom;
    dx_op_b  = $urandom;
    dx_flush = 1'($urandom);
    md_ready = 1'b0;
    md_exception = 1'b0;
    md_result = $urandom;
    wb_grant = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".ctrl_mult"}, 32'(ctrl_mult), 32'd0);
    check_eq({tag, ".ctrl_div"},  32'(ctrl_div),  32'd0);
    check_eq({tag, ".busy"},      32'(busy),      32'd0);
    check_eq({tag, ".wb_req"},    32'(wb_req),    32'd0);
    check_eq({tag, ".inflight"},  inflight_insn,  32'd0);
    check_eq({tag, ".op_a"},      md_op_a,        32'd0);
    check_eq({tag, ".op_b"},      md_op_b,        32'd0);
    check_eq({tag, ".wb_rd"},     32'(wb_rd),     32'd0);
    check_eq({tag, ".wb_data"},   wb_data,        32'd0);
  endtask

  // One complete transaction. do_reset aborts it with a reset in BUSY.
  task automatic run_op(input int n, input bit do_reset);
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a, b, insn, result, exp_data;
    logic [4:0]  exp_rd;
    int          lat, gdel;
    bit          exc, timed_out;

    is_div = 1'($urandom);
    rd     = 5'($urandom);
    if ($urandom_range(0, 7) == 0) rd = 5'd0;
    a = $urandom;
    b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    lat = ($urandom_range(0, 4) == 0) ? TIMEOUT + 3 : $urandom_range(0, 8);
    if (n == 0) begin
      is_div = 1'b0; rd = 5'd5; a = 32'd6; b = 32'd7; lat = 2;
    end
    if (do_reset) lat = TIMEOUT + 3;
    insn   = md_insn(rd, is_div);
    result = is_div ? ((b != 0) ? a / b : 32'd0) : a * b;
    exc    = (is_div && b == 0) || ($urandom_range(0, 7) == 0);
    if (n == 0) exc = 1'b0;
    timed_out = (lat >= TIMEOUT);

    // Squashed or non-mult/div traffic in IDLE must not start anything.
    if ($urandom_range(0, 2) == 0) begin
      noise();
      dx_insn = insn; dx_flush = 1'b1;
      step();
      check_eq("flush.ctrl_mult", 32'(ctrl_mult), 32'd0);
      check_eq("flush.ctrl_div",  32'(ctrl_div),  32'd0);
      check_eq("flush.busy",      32'(busy),      32'd0);
    end
    if ($urandom_range(0, 2) == 0) begin
      noise();
      dx_insn = non_md_insn(); dx_flush = 1'b0;
      step();
      check_eq("nonmd.busy", 32'(busy), 32'd0);
    end

    // Accept cycle.
    noise();
    dx_insn = insn; dx_op_a = a; dx_op_b = b; dx_flush = 1'b0;
    step();
    check_eq("start.ctrl_mult", 32'(ctrl_mult), 32'(!is_div));
    check_eq("start.ctrl_div",  32'(ctrl_div),  32'(is_div));
    check_eq("start.busy",      32'(busy),      32'd1);
    check_eq("start.inflight",  inflight_insn,  insn);
    check_eq("start.op_a",      md_op_a,        a);
    check_eq("start.op_b",      md_op_b,        b);

    noise();
    if ($urandom_range(0, 3) == 0) begin
      md_ready = 1'b1; md_exception = 1'($urandom);
    end
    step();
    check_eq("busy0.ctrl_mult", 32'(ctrl_mult), 32'd0);
    check_eq("busy0.ctrl_div",  32'(ctrl_div),  32'd0);

    for (int i = 0; i < TIMEOUT + 5; i++) begin
      check_eq("busy.busy",     32'(busy),     32'd1);
      check_eq("busy.wb_req",   32'(wb_req),   32'd0);
      check_eq("busy.op_a",     md_op_a,       a);
      check_eq("busy.op_b",     md_op_b,       b);
      check_eq("busy.inflight", inflight_insn, insn);
      noise();
      if (do_reset && i == 2) begin
        dx_insn = '0; dx_flush = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(negedge clock);
        reset = 1'b0;
        step();
        check_eq("post_reset.busy",   32'(busy),   32'd0);
        check_eq("post_reset.wb_req", 32'(wb_req), 32'd0);
        return;
      end
      if (i == lat) begin
        md_ready = 1'b1; md_exception = exc;
        md_result = exc ? $urandom : result;
        step();
        break;
      end
      if (i == TIMEOUT - 1) begin
        step();
        break;
      end
      step();
    end

    if (timed_out || exc) begin
      exp_rd = 5'd30; exp_data = is_div ? 32'd5 : 32'd4;
    end else begin
      exp_rd = rd; exp_data = result;
    end
    if (n == 0) check_eq("s1.data42", exp_data, 32'd42);

    gdel = $urandom_range(0, 3);
    for (int g = 0; g <= gdel; g++) begin
      check_eq("wb.req",   32'(wb_req), 32'd1);
      check_eq("wb.rd",    32'(wb_rd),  32'(exp_rd));
      check_eq("wb.data",  wb_data,     exp_data);
      check_eq("wb.busy",  32'(busy),   32'd1);
      check_eq("wb.op_a",  md_op_a,     a);
      check_eq("wb.op_b",  md_op_b,     b);
      noise();
      if (timed_out) begin
        md_ready = 1'b1; md_exception = 1'($urandom);
      end
      if (g == gdel) wb_grant = 1'b1;
      step();
    end
    check_eq("idle.busy",     32'(busy),      32'd0);
    check_eq("idle.wb_req",   32'(wb_req),    32'd0);
    check_eq("idle.inflight", inflight_insn,  32'd0);
    check_eq("idle.ctrl_mult", 32'(ctrl_mult), 32'd0);
    check_eq("idle.ctrl_div",  32'(ctrl_div),  32'd0);
    wb_grant = 1'b0; md_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      run_op(n, (n == 7) || (n == 23));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence itself were ever to stall.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
